// File: rtl/popcount_share_seq.sv
// Shared sequential population counter: two round-robin requesters feed one
// 7-bit ones-counter that walks a wide word chunk by chunk and accumulates
// its Hamming weight, returned on a valid/ready port tagged with requester id.
module popcount_share_seq #(
  parameter int unsigned DATA_W = 28,
  localparam int unsigned CNT_W = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [DATA_W-1:0] in1_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_id,
  output logic              busy
);

  localparam int unsigned NCHUNK = (DATA_W + 6) / 7;
  localparam int unsigned PAD_W  = NCHUNK * 7;
  localparam int unsigned K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             out_id_q, out_id_d;
  logic             last_id_q, last_id_d;
  logic [2:0]       chunk_cnt;
  logic             grant_any;
  logic             grant_id;

  // Ones in the current chunk; the word is shifted down so chunk k sits at [6:0]
  always_comb begin
    chunk_cnt = '0;
    for (int i = 0; i < 7; i++) begin
      chunk_cnt = chunk_cnt + 3'(word_q[i]);
    end
  end

  // Round-robin grant, only offered in IDLE and outside reset
  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (in0_valid && in1_valid) begin
        grant_any = 1'b1;
        grant_id  = ~last_id_q;
      end else if (in0_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end else if (in1_valid) begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
    end
  end

  assign in0_ready = grant_any && !grant_id;
  assign in1_ready = grant_any && grant_id;
  assign out_valid = (state_q == DONE) && !rst;
  assign out_cnt   = acc_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

  // Next-state and datapath updates
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    acc_d     = acc_q;
    k_d       = k_q;
    out_id_d  = out_id_q;
    last_id_d = last_id_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          word_d    = grant_id ? PAD_W'(in1_data) : PAD_W'(in0_data);
          acc_d     = '0;
          k_d       = '0;
          out_id_d  = grant_id;
          last_id_d = grant_id;
          state_d   = COUNT;
        end
      end
      COUNT: begin
        acc_d  = acc_q + CNT_W'(chunk_cnt);
        word_d = word_q >> 7;
        k_d    = k_q + K_W'(1);
        if (k_q == K_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      word_q    <= '0;
      acc_q     <= '0;
      k_q       <= '0;
      out_id_q  <= 1'b0;
      last_id_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      out_id_q  <= out_id_d;
      last_id_q <= last_id_d;
    end
  end

endmodule

// File: tb/tb_popcount_share_seq.sv
// Scoreboard bench for popcount_share_seq: a 28-bit instance for the main
// scenarios and a 10-bit instance for chunk padding.
module tb_popcount_share_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in0_valid, in0_ready, in1_valid, in1_ready;
  logic [27:0] in0_data, in1_data;
  logic        out_valid, out_ready, out_id, busy;
  logic [4:0]  out_cnt;

  logic        p_in0_valid, p_in0_ready, p_in1_valid, p_in1_ready;
  logic [9:0]  p_in0_data, p_in1_data;
  logic        p_out_valid, p_out_ready, p_out_id, p_busy;
  logic [3:0]  p_out_cnt;

  int total = 0;
  int bad   = 0;
  int q[$];
  int q10[$];
  int mon_e;
  int mon10_e;

  popcount_share_seq #(.DATA_W(28)) u_dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_cnt(out_cnt),
    .out_id(out_id), .busy(busy)
  );

  popcount_share_seq #(.DATA_W(10)) u_dut10 (
    .clk(clk), .rst(rst),
    .in0_valid(p_in0_valid), .in0_ready(p_in0_ready), .in0_data(p_in0_data),
    .in1_valid(p_in1_valid), .in1_ready(p_in1_ready), .in1_data(p_in1_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_cnt(p_out_cnt),
    .out_id(p_out_id), .busy(p_busy)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor for the 28-bit instance: every output handshake pops one expectation
  always begin
    @(negedge clk);
    #2;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got id=%0d cnt=%0d expected none", out_id, out_cnt);
      end else begin
        mon_e = q.pop_front();
        check("out_id", int'(out_id), mon_e >> 8);
        check("out_cnt", int'(out_cnt), mon_e & 255);
      end
    end
  end

  // Monitor for the 10-bit instance
  always begin
    @(negedge clk);
    #2;
    if (p_out_valid && p_out_ready) begin
      if (q10.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out10: got id=%0d cnt=%0d expected none", p_out_id, p_out_cnt);
      end else begin
        mon10_e = q10.pop_front();
        check("out10_id", int'(p_out_id), mon10_e >> 8);
        check("out10_cnt", int'(p_out_cnt), mon10_e & 255);
      end
    end
  end

  // Raise valid, wait for the grant, optionally record the expected result,
  // then drop valid on the negedge after the accept edge
  task automatic send(input int id, input logic [27:0] d, input int exp, input bit push);
    int n;
    n = 0;
    if (id == 0) begin in0_data = d; in0_valid = 1'b1; end
    else         begin in1_data = d; in1_valid = 1'b1; end
    #1;
    while (!((id == 0) ? in0_ready : in1_ready) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_timeout", int'(n < 100), 1);
    if (push && n < 100) q.push_back((id << 8) | exp);
    @(negedge clk);
    if (id == 0) in0_valid = 1'b0;
    else         in1_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || q10.size() != 0 || busy || p_busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", int'(n < 500), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n;
    rst = 1'b1;
    in0_valid = 1'b1; in0_data = '0;
    in1_valid = 1'b0; in1_data = '0;
    out_ready = 1'b1;
    p_in0_valid = 1'b0; p_in0_data = '0;
    p_in1_valid = 1'b0; p_in1_data = '0;
    p_out_ready = 1'b1;

    // Reset held with a pending request
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rst_in0_ready", int'(in0_ready), 0);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_cnt", int'(out_cnt), 0);
      check("rst_out_id", int'(out_id), 0);
      check("rst_busy", int'(busy), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    in0_valid = 1'b0;

    // Single request with 4-cycle latency, then earliest next accept
    send(0, 28'hFFFFFFF, 28, 1'b1);
    #1;
    check("single_ready_pulse", int'(in0_ready), 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      check("single_early_valid", int'(out_valid), 0);
    end
    @(negedge clk);
    #1;
    check("single_lat_valid", int'(out_valid), 1);
    in0_data = 28'h0;
    in0_valid = 1'b1;
    #0;
    check("no_accept_in_done", int'(in0_ready), 0);
    @(negedge clk);
    #1;
    check("accept_after_hs", int'(in0_ready), 1);
    send(0, 28'h0, 0, 1'b1);
    drain();

    // Backpressure in DONE with a competing request pending
    out_ready = 1'b0;
    send(1, 28'h00000FF, 8, 1'b1);
    n = 0;
    #1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("bp_valid_timeout", int'(n < 50), 1);
    in0_data = 28'h0;
    in0_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_cnt", int'(out_cnt), 8);
      check("bp_out_id", int'(out_id), 1);
      check("bp_in0_ready", int'(in0_ready), 0);
      check("bp_in1_ready", int'(in1_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release", int'(out_valid), 0);
    send(0, 28'h0, 0, 1'b1);
    drain();

    // Reset pulse restores last_id so the first contested grant goes to 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Contention: both valid continuously, grants alternate starting at 0
    in0_data = 28'h0000001;
    in1_data = 28'h5555555;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    q.push_back((0 << 8) | 1);
    q.push_back((1 << 8) | 14);
    q.push_back((0 << 8) | 1);
    q.push_back((1 << 8) | 14);
    acc = 0;
    n = 0;
    #1;
    while (acc < 4 && n < 400) begin
      if (in0_ready || in1_ready) begin
        check("grant_order", int'(in1_ready), acc % 2);
        acc++;
      end
      @(negedge clk);
      #1;
      n++;
    end
    check("contention_timeout", int'(n < 400), 1);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    drain();

    // Mid-operation reset discards the in-flight word
    send(1, 28'h1234567, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    rst = 1'b0;
    in0_data = 28'h000000F;
    in1_data = 28'hFFFFFFF;
    in0_valid = 1'b1;
    in1_valid = 1'b1;
    #1;
    check("midrst_grant0", int'(in0_ready), 1);
    check("midrst_grant1", int'(in1_ready), 0);
    q.push_back((0 << 8) | 4);
    @(negedge clk);
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Padding on the 10-bit instance: two chunks, top four bits padded
    p_in1_data = 10'h3FF;
    p_in1_valid = 1'b1;
    #1;
    check("pad_ready", int'(p_in1_ready), 1);
    q10.push_back((1 << 8) | 10);
    @(negedge clk);
    p_in1_valid = 1'b0;
    #1;
    check("pad_valid_e0", int'(p_out_valid), 0);
    @(negedge clk);
    #1;
    check("pad_valid_e1", int'(p_out_valid), 0);
    @(negedge clk);
    #1;
    check("pad_valid_e2", int'(p_out_valid), 1);
    check("pad_cnt_3ff", int'(p_out_cnt), 10);
    @(negedge clk);
    p_in1_data = 10'h000;
    p_in1_valid = 1'b1;
    #1;
    check("pad_ready2", int'(p_in1_ready), 1);
    q10.push_back((1 << 8) | 0);
    @(negedge clk);
    p_in1_valid = 1'b0;
    drain();

    check("q_empty", q.size() + q10.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
